// File: rtl/cpu_divider_multi_if.sv
// Request/result bundle between the execute stage and the iterative divider.
// The divider takes the slave side; the issuing/writeback logic takes the master side.
interface cpu_divider_multi_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 5
);
  logic             div_ready;
  logic             div_start;
  logic [WIDTH-1:0] div_numerator;
  logic [WIDTH-1:0] div_denominator;
  logic             div_signed;
  logic             div_mod;
  logic [TAG_W-1:0] div_tag_in;
  logic             div_flush;
  logic             div_valid;
  logic [WIDTH-1:0] div_result;
  logic [TAG_W-1:0] div_tag;
  logic             div_accept;

  modport master (
    input  div_ready, div_valid, div_result, div_tag,
    output div_start, div_numerator, div_denominator, div_signed, div_mod,
           div_tag_in, div_flush, div_accept
  );

  modport slave (
    output div_ready, div_valid, div_result, div_tag,
    input  div_start, div_numerator, div_denominator, div_signed, div_mod,
           div_tag_in, div_flush, div_accept
  );
endinterface

// File: rtl/cpu_divider_multi.sv
// Iterative restoring divider retiring BITS_PER_CYCLE quotient bits per clock,
// with signed/unsigned div/mod, divide-by-zero fast path, flush and result handshake.
module cpu_divider_multi #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned BITS_PER_CYCLE = 2,
  parameter int unsigned TAG_W          = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  cpu_divider_multi_if.slave   bus
);
  localparam int unsigned ITER  = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] num_q, num_d;
  logic [WIDTH-1:0] den_q, den_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             mod_q, mod_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;

  logic             ready;
  logic             start_fire;
  logic             num_neg, den_neg;
  logic [WIDTH-1:0] num_abs, den_abs;
  logic [WIDTH:0]   step_r, step_t;
  logic [WIDTH-1:0] step_n, step_q, rem_next;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      num_q   <= '0;
      den_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      res_q   <= '0;
      tag_q   <= '0;
      mod_q   <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      den_q   <= den_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      res_q   <= res_d;
      tag_q   <= tag_d;
      mod_q   <= mod_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
    end
  end

  // Magnitudes as unsigned: abs(MIN) wraps to 2^(WIDTH-1), which is the correct unsigned value.
  always_comb begin
    num_neg = bus.div_signed & bus.div_numerator[WIDTH-1];
    den_neg = bus.div_signed & bus.div_denominator[WIDTH-1];
    num_abs = num_neg ? -bus.div_numerator   : bus.div_numerator;
    den_abs = den_neg ? -bus.div_denominator : bus.div_denominator;
  end

  // BITS_PER_CYCLE restoring steps; numerator bits enter MSB-first into a WIDTH+1 bit trial.
  always_comb begin
    step_r = {1'b0, rem_q};
    step_n = num_q;
    step_q = quo_q;
    step_t = '0;
    for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
      step_r = {step_r[WIDTH-1:0], step_n[WIDTH-1]};
      step_n = step_n << 1;
      step_t = step_r - {1'b0, den_q};
      if (!step_t[WIDTH]) step_r = step_t;
      step_q = {step_q[WIDTH-2:0], ~step_t[WIDTH]};
    end
    rem_next = step_r[WIDTH-1:0];
  end

  always_comb begin
    start_fire = bus.div_start & ready & ~bus.div_flush;
    state_d = state_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    den_d   = den_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    res_d   = res_q;
    tag_d   = tag_q;
    mod_d   = mod_q;
    negq_d  = negq_q;
    negr_d  = negr_q;

    unique case (state_q)
      BUSY: begin
        num_d = step_n;
        rem_d = rem_next;
        quo_d = step_q;
        if (cnt_q == '0) begin
          state_d = DONE;
          res_d   = mod_q ? (negr_q ? -rem_next : rem_next)
                          : (negq_q ? -step_q   : step_q);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE:    if (bus.div_accept) state_d = IDLE;
      default: ;
    endcase

    // Start is accepted from IDLE or from DONE in the same cycle the result is taken.
    if (start_fire) begin
      tag_d  = bus.div_tag_in;
      mod_d  = bus.div_mod;
      negq_d = num_neg ^ den_neg;
      negr_d = num_neg;
      num_d  = num_abs;
      den_d  = den_abs;
      rem_d  = '0;
      quo_d  = '0;
      cnt_d  = CNT_W'(ITER - 1);
      if (bus.div_denominator == '0) begin
        state_d = DONE;
        res_d   = bus.div_mod ? bus.div_numerator : '1;
      end else begin
        state_d = BUSY;
      end
    end

    if (bus.div_flush) state_d = IDLE;
  end

  always_comb begin
    ready          = (state_q == IDLE) | ((state_q == DONE) & bus.div_accept);
    bus.div_ready  = ready;
    bus.div_valid  = (state_q == DONE);
    bus.div_result = res_q;
    bus.div_tag    = tag_q;
  end
endmodule

// File: tb/tb_cpu_divider_multi.sv
// Bench for cpu_divider_multi: directed vector table, handshake/flush/reset sequences,
// and random sweeps at BITS_PER_CYCLE 1, 2 and 4 against a behavioural model.
module tb_cpu_divider_multi;
  localparam int unsigned W    = 32;
  localparam int unsigned TW   = 5;
  localparam int unsigned BPC  = 2;
  localparam int unsigned ITER = W / BPC;
  localparam int unsigned NRND = 1000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic       sweep_go   = 1'b0;
  logic [1:0] sweep_done = 2'b00;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    int          lat;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [31:0] n;
    logic [31:0] d;
    logic        s;
    logic        m;
    logic [4:0]  tag;
    logic [31:0] exp;
  } vec_t;

  cpu_divider_multi_if #(.WIDTH(W), .TAG_W(TW)) dif ();
  cpu_divider_multi #(.WIDTH(W), .BITS_PER_CYCLE(BPC), .TAG_W(TW)) u_dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (dif.slave)
  );

  function automatic logic [31:0] ref_div(input logic [31:0] n, input logic [31:0] d,
                                          input logic s, input logic m);
    if (d == 32'd0) return m ? n : 32'hFFFF_FFFF;
    if (s) begin
      if (n == 32'h8000_0000 && d == 32'hFFFF_FFFF) return m ? 32'h0 : 32'h8000_0000;
      return m ? 32'($signed(n) % $signed(d)) : 32'($signed(n) / $signed(d));
    end
    return m ? (n % d) : (n / d);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_pair(output logic [31:0] n, output logic [31:0] d);
    n = $urandom;
    d = $urandom;
    case ($urandom_range(0, 7))
      0: d = 32'd0;
      1: begin n = 32'h8000_0000; d = 32'hFFFF_FFFF; end
      2: d = 32'($urandom_range(1, 15));
      3: d = 32'($urandom_range(1, 255)) | 32'hFFFF_FF00;
      4: n = 32'($urandom_range(0, 1000));
      default: ;
    endcase
  endtask

  task automatic drive(input logic [31:0] n, input logic [31:0] d, input logic s,
                       input logic m, input logic [4:0] tag);
    dif.div_numerator   = n;
    dif.div_denominator = d;
    dif.div_signed      = s;
    dif.div_mod         = m;
    dif.div_tag_in      = tag;
    dif.div_start       = 1'b1;
  endtask

  task automatic wait_valid(output int c);
    c = 1;
    while (!dif.div_valid && c < 4 * int'(ITER)) begin
      step();
      c++;
    end
  endtask

  task automatic run_op(input string name, input logic [31:0] n, input logic [31:0] d,
                        input logic s, input logic m, input logic [4:0] tag,
                        input logic [31:0] exp_res);
    exp_t e;
    int   c;
    e.res = exp_res;
    e.tag = tag;
    e.lat = (d == 32'd0) ? 1 : int'(ITER) + 1;
    sb.push_back(e);
    drive(n, d, s, m, tag);
    step();
    dif.div_start = 1'b0;
    wait_valid(c);
    e = sb.pop_front();
    check({name, "_result"}, dif.div_result, e.res);
    check({name, "_tag"}, 32'(dif.div_tag), 32'(e.tag));
    check({name, "_latency"}, 32'(c), 32'(e.lat));
    dif.div_accept = 1'b1;
    step();
    dif.div_accept = 1'b0;
  endtask

  initial begin
    vec_t        tbl[14];
    logic [31:0] n, d, hold_res;
    logic [4:0]  hold_tag;
    logic        s, m, seen;
    int          c;
    exp_t        e;

    tbl[0]  = '{32'd100,        32'd7,          1'b0, 1'b0, 5'd5,  32'd14};
    tbl[1]  = '{32'd100,        32'd7,          1'b0, 1'b1, 5'd5,  32'd2};
    tbl[2]  = '{32'hFFFF_FF9C,  32'd7,          1'b1, 1'b0, 5'd1,  32'hFFFF_FFF2};
    tbl[3]  = '{32'hFFFF_FF9C,  32'd7,          1'b1, 1'b1, 5'd2,  32'hFFFF_FFFE};
    tbl[4]  = '{32'd100,        32'hFFFF_FFF9,  1'b1, 1'b0, 5'd3,  32'hFFFF_FFF2};
    tbl[5]  = '{32'd100,        32'hFFFF_FFF9,  1'b1, 1'b1, 5'd4,  32'd2};
    tbl[6]  = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 1'b0, 5'd7,  32'h8000_0000};
    tbl[7]  = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 1'b1, 5'd8,  32'd0};
    tbl[8]  = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 1'b0, 5'd9,  32'd0};
    tbl[9]  = '{32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 1'b1, 5'd10, 32'h8000_0000};
    tbl[10] = '{32'd1234,       32'd0,          1'b1, 1'b0, 5'd11, 32'hFFFF_FFFF};
    tbl[11] = '{32'd1234,       32'd0,          1'b1, 1'b1, 5'd12, 32'd1234};
    tbl[12] = '{32'd1234,       32'd0,          1'b0, 1'b0, 5'd13, 32'hFFFF_FFFF};
    tbl[13] = '{32'd1234,       32'd0,          1'b0, 1'b1, 5'd31, 32'd1234};

    dif.div_start = 1'b0; dif.div_numerator = '0; dif.div_denominator = '0;
    dif.div_signed = 1'b0; dif.div_mod = 1'b0; dif.div_tag_in = '0;
    dif.div_flush = 1'b0; dif.div_accept = 1'b0;

    repeat (3) step();
    check("reset_valid",  32'(dif.div_valid), 32'd0);
    check("reset_ready",  32'(dif.div_ready), 32'd1);
    check("reset_tag",    32'(dif.div_tag),   32'd0);
    check("reset_result", dif.div_result,     32'd0);
    rst_n = 1'b1;
    step();

    foreach (tbl[i])
      run_op($sformatf("vec%0d", i), tbl[i].n, tbl[i].d, tbl[i].s, tbl[i].m, tbl[i].tag, tbl[i].exp);

    // Result held while accept stays low, then accept + start back-to-back.
    drive(32'd1000, 32'd3, 1'b0, 1'b0, 5'd17);
    step();
    dif.div_start = 1'b0;
    wait_valid(c);
    check("hold_first_result", dif.div_result, 32'd333);
    hold_res = dif.div_result;
    hold_tag = dif.div_tag;
    for (int i = 0; i < 10; i++) begin
      step();
      check("hold_result", dif.div_result, hold_res);
      check("hold_tag",    32'(dif.div_tag),   32'(hold_tag));
      check("hold_valid",  32'(dif.div_valid), 32'd1);
      check("hold_ready",  32'(dif.div_ready), 32'd0);
    end
    e.res = 32'hFFFF_FFFE; e.tag = 5'd9; e.lat = int'(ITER) + 1;
    sb.push_back(e);
    dif.div_accept = 1'b1;
    drive(32'hFFFF_FF9C, 32'd7, 1'b1, 1'b1, 5'd9);
    step();
    dif.div_accept = 1'b0;
    dif.div_start  = 1'b0;
    check("b2b_valid_low", 32'(dif.div_valid), 32'd0);
    check("b2b_busy",      32'(dif.div_ready), 32'd0);
    wait_valid(c);
    e = sb.pop_front();
    check("b2b_result",  dif.div_result,   e.res);
    check("b2b_tag",     32'(dif.div_tag), 32'(e.tag));
    check("b2b_latency", 32'(c),           32'(e.lat));
    dif.div_accept = 1'b1;
    step();
    dif.div_accept = 1'b0;

    // Flush in the middle of an operation.
    drive(32'd100, 32'd7, 1'b0, 1'b0, 5'd6);
    step();
    dif.div_start = 1'b0;
    repeat (4) step();
    dif.div_flush = 1'b1;
    step();
    dif.div_flush = 1'b0;
    check("flush_valid", 32'(dif.div_valid), 32'd0);
    check("flush_ready", 32'(dif.div_ready), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < int'(ITER) + 4; i++) begin
      step();
      seen |= dif.div_valid;
    end
    check("flush_no_valid", 32'(seen), 32'd0);

    // Flush together with start: start is dropped.
    drive(32'd50, 32'd5, 1'b0, 1'b0, 5'd2);
    dif.div_flush = 1'b1;
    step();
    dif.div_flush = 1'b0;
    dif.div_start = 1'b0;
    check("flush_start_ready", 32'(dif.div_ready), 32'd1);
    seen = 1'b0;
    for (int i = 0; i < int'(ITER) + 4; i++) begin
      step();
      seen |= dif.div_valid;
    end
    check("flush_start_no_valid", 32'(seen), 32'd0);

    // Reset mid-operation.
    drive(32'd100, 32'd7, 1'b0, 1'b0, 5'd21);
    step();
    dif.div_start = 1'b0;
    repeat (3) step();
    rst_n = 1'b0;
    step();
    check("midrst_valid",  32'(dif.div_valid), 32'd0);
    check("midrst_ready",  32'(dif.div_ready), 32'd1);
    check("midrst_tag",    32'(dif.div_tag),   32'd0);
    check("midrst_result", dif.div_result,     32'd0);
    rst_n = 1'b1;
    step();

    sweep_go = 1'b1;
    for (int k = 0; k < int'(NRND); k++) begin
      rand_pair(n, d);
      s = 1'($urandom_range(0, 1));
      m = 1'($urandom_range(0, 1));
      run_op("rnd_bpc2", n, d, s, m, 5'($urandom), ref_div(n, d, s, m));
    end

    c = 0;
    while (sweep_done != 2'b11 && c < 80000) begin
      step();
      c++;
    end
    check("sweep_complete", 32'(sweep_done), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  for (genvar g = 0; g < 2; g++) begin : g_sweep
    localparam int unsigned SBPC  = (g == 0) ? 1 : 4;
    localparam int unsigned SITER = W / SBPC;

    cpu_divider_multi_if #(.WIDTH(W), .TAG_W(TW)) bif ();
    cpu_divider_multi #(.WIDTH(W), .BITS_PER_CYCLE(SBPC), .TAG_W(TW)) u_dut (
      .clock (clk),
      .reset (rst_n),
      .bus   (bif.slave)
    );

    initial begin
      logic [31:0] n, d, exp_res;
      logic        s, m;
      int          c, lat;
      logic [31:0] q_res[$];
      int          q_lat[$];

      bif.div_start = 1'b0; bif.div_numerator = '0; bif.div_denominator = '0;
      bif.div_signed = 1'b0; bif.div_mod = 1'b0; bif.div_tag_in = '0;
      bif.div_flush = 1'b0; bif.div_accept = 1'b0;
      wait (sweep_go);
      for (int k = 0; k < int'(NRND); k++) begin
        rand_pair(n, d);
        s = 1'($urandom_range(0, 1));
        m = 1'($urandom_range(0, 1));
        q_res.push_back(ref_div(n, d, s, m));
        q_lat.push_back((d == 32'd0) ? 1 : int'(SITER) + 1);
        bif.div_numerator   = n;
        bif.div_denominator = d;
        bif.div_signed      = s;
        bif.div_mod         = m;
        bif.div_start       = 1'b1;
        step();
        bif.div_start = 1'b0;
        c = 1;
        while (!bif.div_valid && c < 4 * int'(SITER)) begin
          step();
          c++;
        end
        exp_res = q_res.pop_front();
        lat     = q_lat.pop_front();
        check($sformatf("rnd_bpc%0d_result", SBPC), bif.div_result, exp_res);
        check($sformatf("rnd_bpc%0d_latency", SBPC), 32'(c), 32'(lat));
        bif.div_accept = 1'b1;
        step();
        bif.div_accept = 1'b0;
      end
      sweep_done[g] = 1'b1;
    end
  end
endmodule
